// File: rtl/mysystem_pio_pkg.sv
// Shared definitions for mysystem PIO pollers: Avalon word width, PIO register map
// and the poller FSM state encoding.
package mysystem_pio_pkg;

  localparam int AVM_DATA_W      = 32;
  localparam int PIO_DATA_OFFSET = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_GAP   = 3'd4
  } poll_state_e;

endpackage

// File: rtl/mysystem_done_poller.sv
// Avalon-MM read master that polls one status word until a flag bit is set,
// with a fixed gap between polls, an optional poll limit and abort support.
module mysystem_done_poller
  import mysystem_pio_pkg::*;
#(
  parameter int ADDR_W       = 2,
  parameter int TARGET_ADDR  = PIO_DATA_OFFSET,
  parameter int FLAG_BIT     = 0,
  parameter int READ_LATENCY = 1,
  parameter int POLL_GAP     = 16,
  parameter int MAX_POLLS    = 1000,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic [CNT_W-1:0]      poll_count,
  output logic [AVM_DATA_W-1:0] last_data,
  output logic [ADDR_W-1:0]     avm_address,
  output logic                  avm_read,
  input  logic                  avm_waitrequest,
  input  logic [AVM_DATA_W-1:0] avm_readdata
);

  localparam int LAT_W = $clog2(READ_LATENCY + 1);
  localparam int GAP_W = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;

  // Counters run down to zero, so they are loaded with length-1.
  localparam logic [LAT_W-1:0]  LAT_LOAD = LAT_W'(READ_LATENCY - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD = (POLL_GAP > 0) ? GAP_W'(POLL_GAP - 1) : '0;
  localparam logic [ADDR_W-1:0] TGT      = ADDR_W'(TARGET_ADDR);
  localparam logic [4:0]        FLAG_IDX = 5'(FLAG_BIT);

  poll_state_e      state;
  logic [LAT_W-1:0] lat_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             abort_pend;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic limit_hit(input logic [CNT_W-1:0] v);
    return (MAX_POLLS != 0) && (32'(v) == 32'(MAX_POLLS));
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      poll_count  <= '0;
      last_data   <= '0;
      avm_read    <= 1'b0;
      avm_address <= '0;
      lat_cnt     <= '0;
      gap_cnt     <= '0;
      abort_pend  <= 1'b0;
    end else begin
      done    <= 1'b0;
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_ISSUE;
            busy        <= 1'b1;
            poll_count  <= '0;
            abort_pend  <= 1'b0;
            avm_read    <= 1'b1;
            avm_address <= TGT;
          end
        end
        // The request is never withdrawn once raised; an abort only takes
        // effect after the outstanding read has returned its data.
        ST_ISSUE: begin
          if (abort) abort_pend <= 1'b1;
          if (avm_read && !avm_waitrequest) begin
            state       <= ST_WAIT;
            avm_read    <= 1'b0;
            avm_address <= '0;
            lat_cnt     <= LAT_LOAD;
          end
        end
        ST_WAIT: begin
          if (abort) abort_pend <= 1'b1;
          if (lat_cnt == '0) begin
            last_data  <= avm_readdata;
            poll_count <= sat_inc(poll_count);
            state      <= ST_CHECK;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        ST_CHECK: begin
          if (abort || abort_pend) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            abort_pend <= 1'b0;
          end else if (last_data[FLAG_IDX]) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (limit_hit(poll_count)) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            timeout <= 1'b1;
          end else if (POLL_GAP == 0) begin
            state       <= ST_ISSUE;
            avm_read    <= 1'b1;
            avm_address <= TGT;
          end else begin
            state   <= ST_GAP;
            gap_cnt <= GAP_LOAD;
          end
        end
        ST_GAP: begin
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (gap_cnt == '0) begin
            state       <= ST_ISSUE;
            avm_read    <= 1'b1;
            avm_address <= TGT;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          busy     <= 1'b0;
          avm_read <= 1'b0;
        end
      endcase
    end
  end

endmodule
